maxpool_2x2_16channel: RTL and testbench

MAXPOOL_2X2_16CHANNEL -- requirements
Module: maxpool_2x2_16channel

---
 rtl/maxpool_2x2_16channel.sv | 118 +++++++++++
 tb/tb_maxpool_2x2_16channel.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_16channel.sv
// rtl/maxpool_2x2_16channel.sv - 2x2 stride-2 max pooling over a 16-channel raster stream
// Horizontal pair maxima of even rows wait in a half-width line buffer for the odd row.
module maxpool_2x2_16channel #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDHT*16-1:0] Data_In,
  input  logic                     Valid_In,
  output logic [DATA_WIDHT*16-1:0] Data_Out,
  output logic                     Valid_Out,
  output logic                     Frame_Done
);

  localparam int CH       = 16;
  localparam int PW       = DATA_WIDHT * CH;
  localparam int COL_W    = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
  localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = IMG_WIDHT / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_PLAST = COL_W'(2 * (IMG_WIDHT / 2) - 1);
  localparam logic [ROW_W-1:0] ROW_PLAST = ROW_W'(2 * (IMG_HEIGHT / 2) - 1);

  // Sign-magnitude to monotonic unsigned key, so a plain unsigned compare orders the words.
  function automatic logic [DATA_WIDHT-1:0] f_key(input logic [DATA_WIDHT-1:0] x);
    f_key = x[DATA_WIDHT-1] ? ~x : {1'b1, x[DATA_WIDHT-2:0]};
  endfunction

  function automatic logic [DATA_WIDHT-1:0] f_max(input logic [DATA_WIDHT-1:0] a,
                                                  input logic [DATA_WIDHT-1:0] b);
    f_max = (f_key(a) >= f_key(b)) ? a : b;
  endfunction

  function automatic logic [PW-1:0] f_max_px(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] res;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      res[k*DATA_WIDHT +: DATA_WIDHT] = f_max(a[k*DATA_WIDHT +: DATA_WIDHT],
                                              b[k*DATA_WIDHT +: DATA_WIDHT]);
    end
    return res;
  endfunction

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [PW-1:0]    r_pair;
  logic [PW-1:0]    r_data_out;
  logic             r_valid_out;
  logic             r_frame_done;
  logic [PW-1:0]    r_line [LB_DEPTH];

  logic             w_odd_col;
  logic             w_odd_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_frame_last;
  logic [LB_AW-1:0] w_lb_idx;
  logic [PW-1:0]    w_pair_max;
  logic [PW-1:0]    w_lb_rd;
  logic [PW-1:0]    w_pool;

  assign w_odd_col    = r_col[0];
  assign w_odd_row    = r_row[0];
  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_frame_last = (r_col == COL_PLAST) && (r_row == ROW_PLAST);
  assign w_lb_idx     = LB_AW'(r_col >> 1);
  assign w_pair_max   = f_max_px(r_pair, Data_In);
  assign w_lb_rd      = r_line[w_lb_idx];
  assign w_pool       = f_max_px(w_lb_rd, w_pair_max);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_pair       <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      if (Valid_In) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        // Odd trailing column/row land on even indices, so they only touch pair/line storage.
        if (!w_odd_col) begin
          r_pair <= Data_In;
        end else if (w_odd_row) begin
          r_data_out   <= w_pool;
          r_valid_out  <= 1'b1;
          r_frame_done <= w_frame_last;
        end
      end
    end
  end

  // Every entry is rewritten on the even row before the odd row reads it, so no reset needed.
  always_ff @(posedge clk) begin
    if (Valid_In && w_odd_col && !w_odd_row) begin
      r_line[w_lb_idx] <= w_pair_max;
    end
  end

  assign Data_Out   = r_data_out;
  assign Valid_Out  = r_valid_out;
  assign Frame_Done = r_frame_done;

endmodule

// File: tb/tb_maxpool_2x2_16channel.sv
// tb/tb_maxpool_2x2_16channel.sv - scoreboard bench for maxpool_2x2_16channel (4x4 and 5x5 instances)
module tb_maxpool_2x2_16channel;

  localparam int DW = 32;
  localparam int PW = DW * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [PW-1:0] din   [2];
  logic [PW-1:0] dout  [2];
  logic          vin   [2];
  logic          vout  [2];
  logic          fdone [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            dut;
    logic [PW-1:0] data;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t          sb [$];
  logic [PW-1:0] last_exp [2];

  maxpool_2x2_16channel #(.DATA_WIDHT(DW), .IMG_WIDHT(4), .IMG_HEIGHT(4)) u_dut4 (
    .clk(clk), .rst(rst), .Data_In(din[0]), .Valid_In(vin[0]),
    .Data_Out(dout[0]), .Valid_Out(vout[0]), .Frame_Done(fdone[0])
  );

  maxpool_2x2_16channel #(.DATA_WIDHT(DW), .IMG_WIDHT(5), .IMG_HEIGHT(5)) u_dut5 (
    .clk(clk), .rst(rst), .Data_In(din[1]), .Valid_In(vin[1]),
    .Data_Out(dout[1]), .Valid_Out(vout[1]), .Frame_Done(fdone[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] itof(input int n);
    int          m;
    int          e;
    logic        s;
    logic [31:0] f;
    s = (n < 0);
    m = s ? -n : n;
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    f = (m - (1 << e)) << (23 - e);
    return {s, 8'(127 + e), f[22:0]};
  endfunction

  // Reference ordering: positive beats negative, then magnitude; ties keep a.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31] ? b : a;
    if (!a[31]) return (a[30:0] >= b[30:0]) ? a : b;
    return (a[30:0] <= b[30:0]) ? a : b;
  endfunction

  function automatic logic [31:0] pix(input int pat, input int w, input int r, input int c,
                                      input int k, input int add);
    if (pat == 0) return itof(r * w + c + k + add);
    if (r == 0 && c == 0) return 32'h8000_0000;
    if (r == 1 && c == 1) return 32'h0000_0000;
    if (r == 0 && c == 2) return 32'h0000_0000;
    if (r == 0 && c == 3) return 32'h8000_0000;
    if (r == 2 && c == 2) return itof(-3);
    if (r == 2 && c == 3) return itof(-1);
    if (r == 3 && c == 2) return itof(-2);
    if (r == 3 && c == 3) return itof(-4);
    return itof(-(1 + ((r + c) & 1)));
  endfunction

  function automatic logic [PW-1:0] win(input int pat, input int w, input int r, input int c,
                                        input int add);
    logic [PW-1:0] res;
    logic [31:0]   top;
    logic [31:0]   bot;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      top = fmax(pix(pat, w, r - 1, c - 1, k, add), pix(pat, w, r - 1, c, k, add));
      bot = fmax(pix(pat, w, r, c - 1, k, add), pix(pat, w, r, c, k, add));
      res[k*DW +: DW] = fmax(top, bot);
    end
    return res;
  endfunction

  task automatic drive_frame(input int d, input int w, input int h, input int pat,
                             input int add, input int gap, input int npix);
    int            n;
    logic [PW-1:0] px;
    exp_t          e;
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (npix >= 0 && n >= npix) return;
        @(negedge clk);
        for (int k = 0; k < 16; k++) px[k*DW +: DW] = pix(pat, w, r, c, k, add);
        din[d] = px;
        vin[d] = 1'b1;
        if ((r % 2) == 1 && (c % 2) == 1 && r < 2 * (h / 2) && c < 2 * (w / 2)) begin
          e.dut  = d;
          e.data = win(pat, w, r, c, add);
          e.done = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
          e.cyc  = cyc + 1;
          sb.push_back(e);
        end
        n++;
        if (gap != 0) begin
          @(negedge clk);
          vin[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin[0] = 1'b0;
      vin[1] = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check_val(tag, PW'(sb.size()), PW'(0));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      sb.delete();
      last_exp[0] = '0;
      last_exp[1] = '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (vout[d]) begin
          if (sb.size() == 0) begin
            check_val($sformatf("unexpected_vout%0d", d), PW'(1), PW'(0));
          end else begin
            e = sb.pop_front();
            check_val("out_dut", PW'(d), PW'(e.dut));
            check_val("out_data", dout[d], e.data);
            check_val("out_done", PW'(fdone[d]), PW'(e.done));
            check_val("out_latency", PW'(cyc), PW'(e.cyc));
            last_exp[d] = e.data;
          end
        end else begin
          check_val("hold_data", dout[d], last_exp[d]);
          check_val("idle_done", PW'(fdone[d]), PW'(0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    din[0] = '0;
    din[1] = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val("rst_data", dout[d], PW'(0));
      check_val("rst_valid", PW'(vout[d]), PW'(0));
      check_val("rst_done", PW'(fdone[d]), PW'(0));
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    drive_frame(0, 4, 4, 0, 0, 0, -1);
    idle(3);
    drain("drain_ramp4");

    drive_frame(0, 4, 4, 1, 0, 0, -1);
    idle(3);
    drain("drain_signed");

    drive_frame(1, 5, 5, 0, 0, 0, -1);
    idle(3);
    drain("drain_ramp5");

    drive_frame(0, 4, 4, 0, 0, 1, -1);
    idle(3);
    drain("drain_gaps");

    drive_frame(0, 4, 4, 0, 0, 0, -1);
    drive_frame(0, 4, 4, 0, 100, 0, -1);
    idle(3);
    drain("drain_b2b");

    drive_frame(0, 4, 4, 0, 0, 0, 6);
    @(posedge clk);
    #2;
    check_val("pre_rst_vout", PW'(vout[0]), PW'(1));
    rst    = 1'b0;
    vin[0] = 1'b0;
    #1;
    check_val("mid_rst_data", dout[0], PW'(0));
    check_val("mid_rst_valid", PW'(vout[0]), PW'(0));
    check_val("mid_rst_done", PW'(fdone[0]), PW'(0));
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    drive_frame(0, 4, 4, 0, 0, 0, -1);
    idle(3);
    drain("drain_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
